shift_add_mul_ctrl: RTL and testbench
=====================================

// Module: shift_add_mul_ctrl
// PURPOSE
//  Sequencer that turns the shared combinational FourBitAdder into an unsigned
//  WIDTH x WIDTH multiplier using the shift-and-add method, one adder pass per cycle.
//  It drives the adder's a/b inputs, takes the (WIDTH+1)-bit sum back, and presents
//  a start/busy/done handshake to the surrounding datapath.
//  The adder sits outside this block; the controller only owns sequencing and state.
// PARAMETERS
//  WIDTH    4    operand width; must equal the attached adder width; legal range 2..16
// PORTS
//  clk       in   1          rising-edge clock (the only clock)
//  rst       in   1          synchronous reset, active-high
//  start     in   1          request a multiply; sampled only in IDLE or DONE
//  a         in   WIDTH      multiplicand; captured on the accepting edge
//  b         in   WIDTH      multiplier; captured on the accepting edge
//  busy      out  1          high while in RUN
//  done      out  1          one-cycle pulse; product is final
//  product   out  2*WIDTH    {acc_hi, acc_lo}; final value held until the next accepted start
//  add_a     out  WIDTH      to adder input a
//  add_b     out  WIDTH      to adder input b
//  add_s     in   WIDTH+1    from adder sum output s (combinational, same cycle)
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Internal registers: acc_hi[W-1:0], acc_lo[W-1:0],
//    mcand[W-1:0], cnt[ceil(log2 W):0].
//  - Reset (rst=1 at edge): state=IDLE; acc_hi=acc_lo=mcand=cnt=0.
//    Outputs then read busy=0, done=0, product=0, add_a=0, add_b=0.
//    Reset has priority over everything, including an operation in progress;
//    the partial result is discarded.
//  - Accept: at an edge with start=1 while in IDLE or DONE:
//    mcand<=a; acc_lo<=b; acc_hi<=0; cnt<=WIDTH-1; state<=RUN.
//  - start=1 in RUN is ignored: no restart, no queueing.
//  - RUN, combinational outputs: add_a=acc_hi; add_b = acc_lo[0] ? mcand : 0.
//  - RUN, each edge: {acc_hi, acc_lo} <= {add_s[W:0], acc_lo[W-1:1]}.
//    This is exactly 2W bits; the adder carry lands in acc_hi[W-1].
//  - RUN, each edge: if cnt==0 then state<=DONE, else cnt<=cnt-1.
//    Exactly WIDTH RUN edges occur.
//  - Outside RUN: add_a=add_b=0, so the adder is quiescent and free for other users.
//  - DONE lasts one cycle (done=1), then returns to IDLE, unless start=1 at that
//    edge, which goes straight to RUN (back-to-back).
//  - Latency: accepting edge E. busy=1 for the cycles after edges E..E+W-1.
//    done=1 in the cycle after edge E+W. Throughput: one result per W+1 cycles.
//  - product is a direct view of the accumulator. It is a partial value during RUN.
//    It is exact in DONE and stays stable in IDLE.
//  - Arithmetic: unsigned only; max 15*15=225 fits in 8 bits, so no overflow exists.
//  - busy and done are never high together. done is never high for two consecutive
//    cycles.
// TESTING
//  1. rst held 2 cycles -> busy=0, done=0, product=0, add_a=add_b=0.
//  2. a=0, b=0 start -> done after 5 cycles, product=8'd0; a=15, b=15 -> product=8'd225.
//  3. a=1, b=15 -> 15; a=15, b=1 -> 15; a=0, b=15 -> 0.
//     Check add_b=0 in every RUN cycle where acc_lo[0]=0.
//  4. a=9, b=6 start; pulse start with a=3, b=3 during RUN cycle 2 -> ignored;
//     done once, product=54.
//  5. a=13, b=11 start; assert rst in RUN cycle 3 -> next cycle IDLE, product=0,
//     no done pulse.
//  6. Back-to-back: start held high with a=7, b=5 then a=15, b=2 -> done pulses
//     5 cycles apart; products 35 then 30.

Source files
------------

// File: rtl/shift_add_mul_ctrl_if.sv
// Handshake and adder bus between the shift-add multiply sequencer and its neighbours.
// Carries only wires; no registers and no added latency.
// Callers must hold start until it is accepted; there is no queueing.
interface shift_add_mul_ctrl_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     add_s;

  // Sequencer side: takes requests and the adder sum, drives status and adder operands.
  modport slave (
    input  start, a, b, add_s,
    output busy, done, product, add_a, add_b
  );

  // Datapath side: issues requests, owns the shared adder.
  modport master (
    output start, a, b, add_s,
    input  busy, done, product, add_a, add_b
  );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Unsigned WIDTH x WIDTH shift-and-add multiply sequencer driving an external shared adder.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one result per WIDTH+1 cycles.
// start is accepted only in IDLE or DONE; a start seen during RUN is dropped, not queued.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_add_mul_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept decision and adder operands (adder held at zero outside RUN).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_add_a     = '0;
    w_add_b     = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_add_a = r_acc_hi;
        w_add_b = r_acc_lo[0] ? r_mcand : '0;
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulator: load operands on accept, then shift the adder sum in from the top each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.a;
      r_acc_lo <= bus.b;
      r_acc_hi <= '0;
      r_cnt    <= CW'(WIDTH - 1);
    end else if (r_state == S_RUN) begin
      // The carry (add_s[WIDTH]) becomes acc_hi[WIDTH-1]; the consumed multiplier bit drops out.
      {r_acc_hi, r_acc_lo} <= {bus.add_s, r_acc_lo[WIDTH-1:1]};
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = {r_acc_hi, r_acc_lo};
  assign bus.add_a   = w_add_a;
  assign bus.add_b   = w_add_b;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
module tb_shift_add_mul_ctrl;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shift_add_mul_ctrl_if #(.WIDTH(W)) bus ();

  // External combinational adder shared with the sequencer.
  assign bus.add_s = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
    chk({tag, ".add_a"}, 32'(bus.add_a), 0);
    chk({tag, ".add_b"}, 32'(bus.add_b), 0);
  endtask

  // Called at a negedge. Issues start with (a,b), walks the W RUN cycles against a bench
  // model of the accumulator, and returns at the negedge of the DONE cycle.
  // hold keeps start high throughout RUN; glitch (1..W) pulses start with 3x3 in that RUN cycle.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit hold, input int glitch);
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W:0]   sum;
    logic [W-1:0] exp_b;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    m_hi = '0;
    m_lo = b;
    for (int i = 1; i <= W; i++) begin
      bus.start = hold || (i == glitch);
      if (i == glitch) begin
        bus.a = 4'd3;
        bus.b = 4'd3;
      end
      exp_b = m_lo[0] ? a : '0;
      chk("run.busy", 32'(bus.busy), 1);
      chk("run.done", 32'(bus.done), 0);
      chk("run.add_a", 32'(bus.add_a), 32'(m_hi));
      chk("run.add_b", 32'(bus.add_b), 32'(exp_b));
      chk("run.product", 32'(bus.product), 32'({m_hi, m_lo}));
      sum  = {1'b0, m_hi} + {1'b0, exp_b};
      m_lo = {sum[0], m_lo[W-1:1]};
      m_hi = sum[W:1];
      @(negedge clk);
    end
    chk("done.done", 32'(bus.done), 1);
    chk("done.busy", 32'(bus.busy), 0);
    chk("done.product", 32'(bus.product), 32'(exp));
    chk("done.add_a", 32'(bus.add_a), 0);
    chk("done.add_b", 32'(bus.add_b), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{a: 4'd0,  b: 4'd0,  exp: 8'd0};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
    vecs[2] = '{a: 4'd1,  b: 4'd15, exp: 8'd15};
    vecs[3] = '{a: 4'd15, b: 4'd1,  exp: 8'd15};
    vecs[4] = '{a: 4'd0,  b: 4'd15, exp: 8'd0};
    vecs[5] = '{a: 4'd10, b: 4'd5,  exp: 8'd50};
    vecs[6] = '{a: 4'd13, b: 4'd11, exp: 8'd143};
    vecs[7] = '{a: 4'd6,  b: 4'd9,  exp: 8'd54};

    // Reset held two cycles.
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("reset");
    chk("reset.product", 32'(bus.product), 0);

    // Table of single multiplies, each followed by an idle cycle with the result held.
    foreach (vecs[k]) begin
      do_mul(vecs[k].a, vecs[k].b, vecs[k].exp, 1'b0, 0);
      bus.start = 1'b0;
      @(negedge clk);
      chk_idle_outputs("idle");
      chk("idle.product", 32'(bus.product), 32'(vecs[k].exp));
      @(negedge clk);
      chk("idle2.product", 32'(bus.product), 32'(vecs[k].exp));
    end

    // start pulsed in RUN cycle 2 is ignored; exactly one done.
    do_mul(4'd9, 4'd6, 8'd54, 1'b0, 2);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ignore.no_second_done", 32'(bus.done), 0);
      chk("ignore.no_restart", 32'(bus.busy), 0);
      chk("ignore.product_held", 32'(bus.product), 54);
    end

    // Reset in RUN cycle 3 discards the operation.
    bus.start = 1'b1;
    bus.a     = 4'd13;
    bus.b     = 4'd11;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstrun.busy1", 32'(bus.busy), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("rstrun");
    chk("rstrun.product", 32'(bus.product), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rstrun.no_done", 32'(bus.done), 0);
      chk("rstrun.no_busy", 32'(bus.busy), 0);
    end

    // Back-to-back with start held high: second accept happens on the DONE edge.
    do_mul(4'd7, 4'd5, 8'd35, 1'b1, 0);
    do_mul(4'd15, 4'd2, 8'd30, 1'b0, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk_idle_outputs("b2b.after");
    chk("b2b.product_held", 32'(bus.product), 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
